// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ST_OPEN  = 1'b0,
    ST_LOCK1 = 1'b1
  } state_t;

  localparam logic PORT_PIPE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive refused port-1 request cycles.
import dmem_arb_pkg::*;

module dmem_arb_starve_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       gnt,
  input  logic [3:0] limit,
  output logic       at_limit
);

  logic [3:0] cnt;

  // Clear when the requester is served or idle, count refusals up to the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt < limit) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline (port 0) has priority, DMA/debug
// (port 1) gets anti-starvation turns and an atomic lock.
// Optional macro DMEM_ARB_STATS_EN adds conflict and stall counters.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_store_type,
  input  logic [2:0]        p0_load_type,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_store_type,
  input  logic [2:0]        p1_load_type,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              stall,
  output logic              mem_write,
  output logic [1:0]        mem_store_type,
  output logic [2:0]        mem_load_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       p0_stall_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t state_q, state_d;
  logic   at_limit;
  logic   rd_pend;
  logic   rd_port;

  dmem_arb_starve_ctr u_starve (
    .clk      (clk),
    .rst      (rst),
    .req      (p1_req),
    .gnt      (p1_gnt),
    .limit    (LIMIT),
    .at_limit (at_limit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_OPEN;
    else      state_q <= state_d;
  end

  // Lock is taken and released only on port-1 grants.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN:  if (p1_gnt && p1_lock)  state_d = ST_LOCK1;
      ST_LOCK1: if (p1_gnt && !p1_lock) state_d = ST_OPEN;
      default:  state_d = ST_OPEN;
    endcase
  end

  // Grant decode; reset gates grants so all downstream outputs go quiet.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst) begin
      case (state_q)
        ST_OPEN: begin
          if (p0_req && !(at_limit && p1_req)) p0_gnt = 1'b1;
          else if (p1_req)                     p1_gnt = 1'b1;
        end
        ST_LOCK1: p1_gnt = p1_req;
        default: ;
      endcase
    end
  end

  assign stall = rst & p0_req & ~p0_gnt;

  // Route the winner's fields to memory; all zero when nobody is granted.
  always_comb begin
    mem_write      = 1'b0;
    mem_store_type = '0;
    mem_load_type  = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    if (p0_gnt) begin
      mem_write      = p0_we;
      mem_store_type = p0_store_type;
      mem_load_type  = p0_load_type;
      mem_addr       = p0_addr;
      mem_wdata      = p0_wdata;
    end else if (p1_gnt) begin
      mem_write      = p1_we;
      mem_store_type = p1_store_type;
      mem_load_type  = p1_load_type;
      mem_addr       = p1_addr;
      mem_wdata      = p1_wdata;
    end
  end

  // Remember which port issued a load so next-cycle data goes back to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend <= 1'b0;
      rd_port <= PORT_PIPE;
    end else begin
      rd_pend <= (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);
      rd_port <= p1_gnt ? PORT_DMA : PORT_PIPE;
    end
  end

  // Response steering; the non-owning port sees zero data.
  always_comb begin
    p0_rvalid = rd_pend & (rd_port == PORT_PIPE);
    p1_rvalid = rd_pend & (rd_port == PORT_DMA);
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating conflict and stall statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
      p0_stall_cnt <= '0;
    end else begin
      if (p0_req && p1_req && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 16'd1;
      if (stall && p0_stall_cnt != '1)            p0_stall_cnt <= p0_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a read-response scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [1:0]  p0_store_type, p1_store_type;
  logic [2:0]  p0_load_type, p1_load_type;
  logic [11:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, stall, mem_write;
  logic [31:0] p0_rdata, p1_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_store_type;
  logic [2:0]  mem_load_type;
  logic [11:0] mem_addr;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, p0_stall_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [32:0] sb[$];

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_store_type(p0_store_type),
    .p0_load_type(p0_load_type), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_store_type(p1_store_type),
    .p1_load_type(p1_load_type), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .stall(stall), .mem_write(mem_write), .mem_store_type(mem_store_type),
    .mem_load_type(mem_load_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .p0_stall_cnt(p0_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [11:0] a);
    return 32'hD000_0000 | {20'd0, a};
  endfunction

  // Synchronous memory: data for the presented address appears next cycle.
  always @(posedge clk) mem_rdata <= pat(mem_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".p0_gnt"}, {31'd0, p0_gnt}, 0);
    chk({tag, ".p1_gnt"}, {31'd0, p1_gnt}, 0);
    chk({tag, ".stall"}, {31'd0, stall}, 0);
    chk({tag, ".p0_rvalid"}, {31'd0, p0_rvalid}, 0);
    chk({tag, ".p1_rvalid"}, {31'd0, p1_rvalid}, 0);
    chk({tag, ".p0_rdata"}, p0_rdata, 0);
    chk({tag, ".p1_rdata"}, p1_rdata, 0);
    chk({tag, ".mem_write"}, {31'd0, mem_write}, 0);
    chk({tag, ".mem_addr"}, {20'd0, mem_addr}, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_types"}, {27'd0, mem_store_type, mem_load_type}, 0);
  endtask

  task automatic check_resp(input string tag);
    logic [32:0] e;
    logic        v0, v1;
    logic [31:0] d0, d1;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e[32]) begin v1 = 1'b1; d1 = e[31:0]; end
      else       begin v0 = 1'b1; d0 = e[31:0]; end
    end
    chk({tag, ".p0_rvalid"}, {31'd0, p0_rvalid}, {31'd0, v0});
    chk({tag, ".p1_rvalid"}, {31'd0, p1_rvalid}, {31'd0, v1});
    chk({tag, ".p0_rdata"}, p0_rdata, d0);
    chk({tag, ".p1_rdata"}, p1_rdata, d1);
  endtask

  // One cycle: drive requests, check grant/stall/memory side, then the response.
  task automatic step(input string tag,
                      input logic r0, input logic w0, input logic [11:0] a0,
                      input logic r1, input logic w1, input logic lk, input logic [11:0] a1,
                      input logic e0, input logic e1, input logic es);
    logic [11:0] ea;
    logic [31:0] ewd;
    logic        ew;
    logic [4:0]  et;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = 32'hA000_0000 | {20'd0, a0};
    p0_store_type = 2'b10; p0_load_type = 3'b100;
    p1_req = r1; p1_we = w1; p1_lock = lk; p1_addr = a1; p1_wdata = 32'hB000_0000 | {20'd0, a1};
    p1_store_type = 2'b01; p1_load_type = 3'b011;
    #2;
    ea = '0; ewd = '0; ew = 1'b0; et = '0;
    if (e0) begin
      ea = a0; ew = w0; ewd = 32'hA000_0000 | {20'd0, a0}; et = 5'b10100;
    end else if (e1) begin
      ea = a1; ew = w1; ewd = 32'hB000_0000 | {20'd0, a1}; et = 5'b01011;
    end
    chk({tag, ".p0_gnt"}, {31'd0, p0_gnt}, {31'd0, e0});
    chk({tag, ".p1_gnt"}, {31'd0, p1_gnt}, {31'd0, e1});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, es});
    chk({tag, ".mem_addr"}, {20'd0, mem_addr}, {20'd0, ea});
    chk({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, ew});
    chk({tag, ".mem_wdata"}, mem_wdata, ewd);
    chk({tag, ".mem_types"}, {27'd0, mem_store_type, mem_load_type}, {27'd0, et});
    if (e0 && !w0)      sb.push_back({1'b0, pat(a0)});
    else if (e1 && !w1) sb.push_back({1'b1, pat(a1)});
    @(posedge clk);
    #1;
    check_resp(tag);
  endtask

  initial begin
    rst = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h010; p0_wdata = '1;
    p0_store_type = 2'b11; p0_load_type = 3'b111;
    p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1; p1_addr = 12'h020; p1_wdata = '1;
    p1_store_type = 2'b11; p1_load_type = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
    rst = 1'b1;

    // Single pipeline load.
    step("p0_load", 1, 0, 12'h010, 0, 0, 0, 12'h000, 1, 0, 0);

    // Continuous dual request: four port-0 grants, then one port-1 turn.
    for (int unsigned i = 0; i < 10; i++) begin
      if (i % 5 == 4)
        step("dual_p1", 1, 0, 12'h100 + 12'(i * 4), 1, 0, 0, 12'h200 + 12'(i * 4), 0, 1, 1);
      else
        step("dual_p0", 1, 0, 12'h100 + 12'(i * 4), 1, 0, 0, 12'h200 + 12'(i * 4), 1, 0, 0);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd10);
    chk("p0_stall_cnt", {16'd0, p0_stall_cnt}, 32'd2);
`endif

    // Locked read-modify-write by port 1 while the pipeline keeps asking.
    for (int unsigned i = 0; i < 4; i++)
      step("lock_wait", 1, 0, 12'h030, 1, 1, 1, 12'h020, 1, 0, 0);
    step("lock_store", 1, 0, 12'h030, 1, 1, 1, 12'h020, 0, 1, 1);
    step("lock_hold", 1, 0, 12'h030, 0, 0, 0, 12'h000, 0, 0, 1);
    step("lock_load", 1, 0, 12'h030, 1, 0, 0, 12'h020, 0, 1, 1);
    step("unlock_p0", 1, 0, 12'h030, 0, 0, 0, 12'h000, 1, 0, 0);

    // Back-to-back loads from different ports, then a store with no response.
    step("b2b_p0", 1, 0, 12'h004, 0, 0, 0, 12'h000, 1, 0, 0);
    step("b2b_p1", 0, 0, 12'h000, 1, 0, 0, 12'h008, 0, 1, 0);
    step("p0_store", 1, 1, 12'h044, 0, 0, 0, 12'h000, 1, 0, 0);
    step("idle", 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0);

    // Reset while locked with a read response in flight.
    step("pre_rst", 0, 0, 12'h000, 1, 0, 1, 12'h050, 0, 1, 0);
    p0_req = 1'b1; p1_req = 1'b1;
    rst = 1'b0;
    #1;
    chk_quiet("rst_mid");
    @(posedge clk);
    #1;
    chk_quiet("rst_hold");
    p0_req = 1'b0; p1_req = 1'b0;
    rst = 1'b1;
    step("post_rst_idle", 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0);
    step("post_rst_p0", 1, 0, 12'h060, 0, 0, 0, 12'h000, 1, 0, 0);
    step("post_rst_dual", 1, 0, 12'h064, 1, 0, 0, 12'h068, 1, 0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
